res_mem_drain: RTL and testbench

Reads the PE array's result memory after a computation and streams the words out over a valid/ready interface. It is the read-side counterpart to the datapath's result-memory write path. The block is started by the top-level done pulse. It hides the memory's 1-cycle read latency behind a 2-entry skid buffer, so the stream sustains 1 word/cycle under continuous ready.

---
 rtl/res_drain_pkg.sv | 18 +
 rtl/res_mem_drain_if.sv | 27 ++
 rtl/res_mem_drain_skid_fifo.sv | 51 +++++
 rtl/res_mem_drain.sv | 133 +++++++++++++
 tb/tb_res_mem_drain.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/res_drain_pkg.sv
// Shared types and default constants for the result-memory drain block.
//   state_t     : drain controller states
//   DATA_W      : default result word width
//   ADDR_W      : default result-memory address width
//   SKID_DEPTH  : entries in the output skid buffer (covers 1-cycle read latency)
package res_drain_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/res_mem_drain_if.sv
// Valid/ready stream carrying drained result words.
//   outValidOut : word valid (source -> sink)
//   outReadyIn  : sink ready (sink -> source)
//   outDataOut  : result word
//   outIdxOut   : result-memory index the word was read from
//   outLastOut  : marks the final word of a drain
// master = drain side, slave = consumer side.
interface res_mem_drain_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              outValidOut;
  logic              outReadyIn;
  logic [DATA_W-1:0] outDataOut;
  logic [ADDR_W-1:0] outIdxOut;
  logic              outLastOut;

  modport master (
    output outValidOut, outDataOut, outIdxOut, outLastOut,
    input  outReadyIn
  );

  modport slave (
    input  outValidOut, outDataOut, outIdxOut, outLastOut,
    output outReadyIn
  );
endinterface

// File: rtl/res_mem_drain_skid_fifo.sv
// drain_skid_fifo: 2-entry FIFO absorbing words already in flight from the
// result memory when the sink stalls.
//   clk, rst   : clock, synchronous active-high reset (flushes pointers/count)
//   push/push_data : write one entry
//   pop        : remove head entry (caller guarantees count != 0)
//   count      : current occupancy 0..2
//   head_data  : payload at the head, meaningful only while count != 0
module drain_skid_fifo
  import res_drain_pkg::*;
#(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head_data
);

  logic [W-1:0] mem_reg [SKID_DEPTH];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;

  // Storage needs no reset; validity is tracked by count_reg alone.
  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

  assign count     = count_reg;
  assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/res_mem_drain.sv
// res_mem_drain: after a computation, reads DEPTH words from the PE array's
// result memory and streams them out in address order. Reads are throttled so
// that buffered + in-flight words never exceed the skid depth, which keeps
// 1 word/cycle under continuous ready while tolerating arbitrary stalls.
//   clk, rst      : clock, synchronous active-high reset
//   startIn       : start pulse, accepted only in IDLE
//   memRdEnOut    : result-memory read enable
//   memRdAddrOut  : result-memory read address
//   memRdDataIn   : read data, valid the cycle after memRdEnOut
//   stream        : output word stream (res_mem_drain_if.master)
//   busyOut       : drain in progress
//   doneOut       : 1-cycle pulse after the last transfer
//   checksumOut   : running sum of transferred words (only with
//                   RES_DRAIN_CHECKSUM_EN defined)
module res_mem_drain #(
  parameter int N      = 4,
  parameter int DEPTH  = N * N,
  parameter int DATA_W = res_drain_pkg::DATA_W,
  parameter int ADDR_W = res_drain_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startIn,
  output logic               memRdEnOut,
  output logic [ADDR_W-1:0]  memRdAddrOut,
  input  logic [DATA_W-1:0]  memRdDataIn,
  res_mem_drain_if.master    stream,
  output logic               busyOut,
  output logic               doneOut
`ifdef RES_DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]  checksumOut
`endif
);
  import res_drain_pkg::*;

  localparam int W = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_reg;
  logic [ADDR_W:0]   issue_cnt_reg;     // one extra bit so DEPTH itself is representable
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_idx_reg;

  logic [1:0]        fifo_count;
  logic [W-1:0]      head_data;
  logic              head_valid;
  logic              head_last;
  logic              pop;
  logic              rd_en;
  logic [2:0]        occ_after_pop;

  assign head_valid = (fifo_count != 2'd0);
  assign head_last  = head_data[W-1];
  assign pop        = head_valid && stream.outReadyIn;

  // Occupancy the buffer would reach if nothing new were issued this cycle;
  // issuing only below SKID_DEPTH guarantees the returning word has a slot.
  assign occ_after_pop = 3'(fifo_count) + 3'(inflight_reg) - 3'(pop);
  assign rd_en = (state_reg == RUN) && (issue_cnt_reg < DEPTH_C) &&
                 (occ_after_pop < 3'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      issue_cnt_reg    <= '0;
      inflight_reg     <= 1'b0;
      inflight_idx_reg <= '0;
    end else begin
      inflight_reg <= rd_en;
      if (rd_en) begin
        inflight_idx_reg <= issue_cnt_reg[ADDR_W-1:0];
        issue_cnt_reg    <= issue_cnt_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (startIn) begin
            state_reg     <= RUN;
            issue_cnt_reg <= '0;
          end
        end
        RUN: begin
          if (pop && head_last) state_reg <= FIN;
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Return path: data arrives one cycle after issue and is tagged with the
  // address it came from. A reset clears inflight_reg, discarding stale data.
  drain_skid_fifo #(.W(W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data ({(inflight_idx_reg == LAST_IDX), inflight_idx_reg, memRdDataIn}),
    .pop       (pop),
    .count     (fifo_count),
    .head_data (head_data)
  );

  assign memRdEnOut   = rd_en;
  assign memRdAddrOut = rd_en ? issue_cnt_reg[ADDR_W-1:0] : '0;

  // Payload outputs are forced to zero when empty so a flushed buffer shows
  // nothing; while valid they come straight from the (stable) head entry.
  assign stream.outValidOut = head_valid;
  assign stream.outDataOut  = head_valid ? head_data[DATA_W-1:0] : '0;
  assign stream.outIdxOut   = head_valid ? head_data[DATA_W +: ADDR_W] : '0;
  assign stream.outLastOut  = head_valid && head_last;

  assign busyOut = (state_reg == RUN);
  assign doneOut = (state_reg == FIN);

`ifdef RES_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_reg <= '0;
    end else if ((state_reg == IDLE) && startIn) begin
      checksum_reg <= '0;
    end else if (pop) begin
      checksum_reg <= checksum_reg + head_data[DATA_W-1:0];
    end
  end

  assign checksumOut = checksum_reg;
`endif

endmodule

// File: tb/tb_res_mem_drain.sv
// Self-checking bench for res_mem_drain: table-driven full-rate drain plus
// hand-written back-pressure, random-ready, spurious-start, mid-drain reset
// and all-ones sequences. Cycle k of a test is the clock period in which
// inputs are driven and outputs sampled (at the falling edge).
module tb_res_mem_drain;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TLEN  = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic          startIn;
  logic          memRdEnOut;
  logic [AW-1:0] memRdAddrOut;
  logic [DW-1:0] memRdDataIn;
  logic          busyOut;
  logic          doneOut;
`ifdef RES_DRAIN_CHECKSUM_EN
  logic [DW-1:0] checksumOut;
`endif

  res_mem_drain_if #(.DATA_W(DW), .ADDR_W(AW)) sif ();

  res_mem_drain #(.N(4), .DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .startIn      (startIn),
    .memRdEnOut   (memRdEnOut),
    .memRdAddrOut (memRdAddrOut),
    .memRdDataIn  (memRdDataIn),
    .stream       (sif),
    .busyOut      (busyOut),
    .doneOut      (doneOut)
`ifdef RES_DRAIN_CHECKSUM_EN
    ,
    .checksumOut  (checksumOut)
`endif
  );

  always #5 clk = ~clk;

  // Result memory model with 1-cycle registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (memRdEnOut) memRdDataIn <= mem[memRdAddrOut];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
  endtask

  // Expected per-cycle outputs of the full-rate drain (start in cycle 10).
  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic          valid;
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
    logic          busy;
    logic          done;
  } vec_t;
  vec_t tbl [TLEN];

  // Scoreboard state.
  int            fill_mode;
  int            sb_idx, issued, popped, done_cnt, max_out;
  logic [DW-1:0] sb_sum;
  logic          stall_prev;
  logic [63:0]   held;

  function automatic logic [DW-1:0] exp_word(input int i);
    if (fill_mode == 0) return DW'(3 * i + 1);
    return 16'hFFFF;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({memRdEnOut, memRdAddrOut, sif.outValidOut, sif.outDataOut,
                sif.outIdxOut, sif.outLastOut, busyOut, doneOut});
  endfunction

  task automatic sb_clear();
    sb_idx = 0; issued = 0; popped = 0; done_cnt = 0; max_out = 0;
    sb_sum = '0; stall_prev = 1'b0; held = '0;
  endtask

  task automatic fill_mem(input int mode);
    fill_mode = mode;
    for (int i = 0; i < DEPTH; i++) mem[i] = (mode == 0) ? DW'(3 * i + 1) : 16'hFFFF;
  endtask

  task automatic drive(input logic s, input logic r);
    startIn = s;
    sif.outReadyIn = r;
    #1;
  endtask

  // Scoreboard one cycle, then advance to the next falling edge.
  task automatic sample();
    logic [63:0] now;
    now = 64'({sif.outValidOut, sif.outLastOut, sif.outIdxOut, sif.outDataOut});
    if (stall_prev) check("hold_stable", now, held);
    stall_prev = sif.outValidOut && !sif.outReadyIn;
    held = now;
    if (memRdEnOut) issued++;
    if (sif.outValidOut && sif.outReadyIn) begin
      check("word_data", sif.outDataOut, exp_word(sb_idx));
      check("word_idx", sif.outIdxOut, sb_idx);
      check("word_last", sif.outLastOut, sb_idx == DEPTH - 1);
      sb_sum = sb_sum + exp_word(sb_idx);
      sb_idx++;
      popped++;
    end
    if (issued - popped > max_out) max_out = issued - popped;
    if (doneOut) begin
      done_cnt++;
`ifdef RES_DRAIN_CHECKSUM_EN
      check("checksum_at_done", checksumOut, sb_sum);
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    sb_clear();
  endtask

  task automatic run_full(input logic spur, input logic use_table);
    do_reset();
    for (int k = 0; k < TLEN; k++) begin
      drive((k == 10) || (spur && k == 15), 1'b1);
      if (use_table) begin
        check("t_ctrl", {busyOut, doneOut, memRdEnOut, sif.outValidOut},
              {tbl[k].busy, tbl[k].done, tbl[k].en, tbl[k].valid});
        if (tbl[k].en) check("t_addr", memRdAddrOut, tbl[k].addr);
        if (tbl[k].valid)
          check("t_word", {sif.outLastOut, sif.outIdxOut, sif.outDataOut},
                {tbl[k].last, tbl[k].idx, tbl[k].data});
      end
      sample();
    end
    check("full_word_count", sb_idx, DEPTH);
    check("full_done_count", done_cnt, 1);
  endtask

  initial begin
    rst = 1'b1;
    startIn = 1'b0;
    sif.outReadyIn = 1'b0;
    void'($urandom(32'd20240611));

    for (int k = 0; k < TLEN; k++) begin
      tbl[k].en    = (k >= 11) && (k <= 26);
      tbl[k].addr  = tbl[k].en ? AW'(k - 11) : '0;
      tbl[k].valid = (k >= 13) && (k <= 28);
      tbl[k].data  = tbl[k].valid ? DW'(3 * (k - 13) + 1) : '0;
      tbl[k].idx   = tbl[k].valid ? AW'(k - 13) : '0;
      tbl[k].last  = (k == 28);
      tbl[k].busy  = (k >= 11) && (k <= 28);
      tbl[k].done  = (k == 29);
    end

    // Full-rate drain.
    fill_mem(0);
    run_full(1'b0, 1'b1);
`ifdef RES_DRAIN_CHECKSUM_EN
    check("checksum_full", checksumOut, 16'h0178);
`endif

    // Back-pressure: ready low in cycles 14..20.
    do_reset();
    for (int k = 0; k < 46; k++) begin
      drive(k == 10, !((k >= 14) && (k <= 20)));
      if (k >= 14 && k <= 20)
        check("bp_hold", {sif.outValidOut, sif.outIdxOut, sif.outDataOut},
              {1'b1, 4'd1, 16'd4});
      sample();
    end
    check("bp_word_count", sb_idx, DEPTH);
    check("bp_done_count", done_cnt, 1);
    check("bp_max_outstanding", max_out, 2);

    // Random ready, three back-to-back drains.
    do_reset();
    for (int d = 0; d < 3; d++) begin
      int budget;
      sb_clear();
      drive(1'b1, 1'($urandom_range(0, 1)));
      sample();
      budget = 0;
      while (done_cnt == 0 && budget < 200) begin
        drive(1'b0, 1'($urandom_range(0, 1)));
        sample();
        budget++;
      end
      check("rand_done_seen", done_cnt, 1);
      check("rand_word_count", sb_idx, DEPTH);
      check("rand_max_outstanding", max_out <= 2, 1'b1);
    end
    sb_clear();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1);
      sample();
    end
    check("rand_no_extra_done", done_cnt, 0);
    check("rand_idle_busy", busyOut, 1'b0);

    // Spurious start during RUN must not disturb the stream.
    run_full(1'b1, 1'b1);

    // Reset in cycle 18, restart in cycle 25.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      rst = (k == 18);
      drive((k == 10) || (k == 25), 1'b1);
      if (k >= 19 && k <= 25) check("midrst_zero", all_outs(), 64'd0);
      sample();
      if (k == 18) sb_clear();
    end
    rst = 1'b0;
    check("midrst_word_count", sb_idx, DEPTH);
    check("midrst_done_count", done_cnt, 1);

    // All-ones words: data width boundary and checksum wrap.
    fill_mem(1);
    run_full(1'b0, 1'b0);
`ifdef RES_DRAIN_CHECKSUM_EN
    check("checksum_ones", checksumOut, 16'hFFF0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
